// File: rtl/circuit4_sched.sv
// rtl/circuit4_sched.sv - multi-cycle scheduled circuit_4 controller with one shared add/sub ALU
// Optional feature macro: CIRCUIT4_DUAL_ALU_EN (second adder, ADD_E state removed, latency 4)
module circuit4_sched #(
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic [DW-1:0]   c,
  output logic            busy,
  output logic            done,
  output logic [DW/2-1:0] z,
  output logic [DW/2-1:0] x
);

`ifdef CIRCUIT4_DUAL_ALU_EN
  typedef enum logic [2:0] {IDLE, ADD_D, SUB_F, SEL, OUT} state_t;
`else
  typedef enum logic [2:0] {IDLE, ADD_D, ADD_E, SUB_F, SEL, OUT} state_t;
`endif

  state_t state, state_n;

  logic [DW-1:0] ra, rb, rc, rd, re, rf, rg, rh;
  logic          rlt, req;

  logic [DW-1:0] alu_b, alu_y;
  logic          alu_sub;
  logic [DW-1:0] g_sel, x_full, z_full;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state sequencing; start is only honoured in IDLE
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = ADD_D;
`ifdef CIRCUIT4_DUAL_ALU_EN
      ADD_D: state_n = SUB_F;
`else
      ADD_D: state_n = ADD_E;
      ADD_E: state_n = SUB_F;
`endif
      SUB_F: state_n = SEL;
      SEL:   state_n = OUT;
      OUT:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Shared ALU operand/mode decode from the current state
  always_comb begin
    alu_b   = rb;
    alu_sub = 1'b0;
    case (state)
`ifndef CIRCUIT4_DUAL_ALU_EN
      ADD_E: alu_b = rc;
`endif
      SUB_F: alu_sub = 1'b1;
      default: ;
    endcase
  end

  assign alu_y  = alu_sub ? (ra - alu_b) : (ra + alu_b);
  assign g_sel  = rlt ? re : rd;
  assign x_full = rh << rlt;
  assign z_full = rg >> req;

`ifdef CIRCUIT4_DUAL_ALU_EN
  logic [DW-1:0] add2_y;
  assign add2_y = ra + rc;
`endif

  // Datapath registers and registered outputs, loaded per scheduled step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra <= '0; rb <= '0; rc <= '0;
      rd <= '0; re <= '0; rf <= '0;
      rg <= '0; rh <= '0;
      rlt <= 1'b0; req <= 1'b0;
      z <= '0; x <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == OUT);
      case (state)
        IDLE: begin
          if (start) begin
            ra <= a; rb <= b; rc <= c;
          end
        end
        ADD_D: begin
          rd <= alu_y;
`ifdef CIRCUIT4_DUAL_ALU_EN
          re <= add2_y;
`endif
        end
`ifndef CIRCUIT4_DUAL_ALU_EN
        ADD_E: re <= alu_y;
`endif
        SUB_F: begin
          rf  <= alu_y;
          rlt <= (rd < re);
          req <= (rd == re);
        end
        SEL: begin
          rg <= g_sel;
          rh <= req ? rf : g_sel;
        end
        OUT: begin
          x <= x_full[DW/2-1:0];
          z <= z_full[DW/2-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_circuit4_sched.sv
// tb/tb_circuit4_sched.sv - directed self-checking bench for circuit4_sched
module tb_circuit4_sched;
  localparam int DW = 64;
`ifdef CIRCUIT4_DUAL_ALU_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 5;
`endif
  localparam int PER = LAT + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] a = '0, b = '0, c = '0;
  logic          busy, done;
  logic [DW/2-1:0] z, x;

  int vectors = 0;
  int miscompares = 0;

  circuit4_sched #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .c(c),
    .busy(busy), .done(done), .z(z), .x(x)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One framed operation; px/pz are the results expected to be held until completion
  task automatic run_op(input string tag, input logic [63:0] ia, input logic [63:0] ib,
                        input logic [63:0] ic, input logic [31:0] ex, input logic [31:0] ez,
                        input logic [31:0] px, input logic [31:0] pz, input bit poke);
    a = ia; b = ib; c = ic; start = 1'b1;
    tick();
    start = poke;
    a = '1; b = '1; c = 64'h1234;
    check({tag, ".busy_e0"}, 64'(busy), 64'd1);
    for (int i = 1; i < LAT; i++) begin
      tick();
      check({tag, ".hold"}, {31'd0, done, x}, {32'd0, px});
      check({tag, ".hold_z"}, {31'd0, busy, z}, {32'd1, pz});
    end
    tick();
    start = 1'b0;
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".x"}, 64'(x), 64'(ex));
    check({tag, ".z"}, 64'(z), 64'(ez));
    check({tag, ".busy_end"}, 64'(busy), 64'd0);
    tick();
    check({tag, ".done_low"}, {62'd0, done, busy}, 64'd0);
  endtask

  logic [63:0] va [3];
  logic [63:0] vb [3];
  logic [63:0] vc [3];
  logic [31:0] vx [3];
  logic [31:0] vz [3];

  initial begin
    va[0] = 64'd5; vb[0] = 64'd3; vc[0] = 64'd10; vx[0] = 32'd30;         vz[0] = 32'd15;
    va[1] = 64'd1; vb[1] = 64'd9; vc[1] = 64'd2;  vx[1] = 32'd10;         vz[1] = 32'd10;
    va[2] = 64'd4; vb[2] = 64'd6; vc[2] = 64'd6;  vx[2] = 32'hFFFF_FFFE;  vz[2] = 32'd5;

    #1;
    check("reset.state", {30'd0, busy, done, 32'd0}, 64'd0);
    check("reset.zx", {z, x}, 64'd0);
    #12 rst_n = 1'b1;
    tick();

    run_op("t1", 64'd5, 64'd3, 64'd10, 32'd30, 32'd15, 32'd0, 32'd0, 1'b0);
    check("t1.rd", dut.rd, 64'd8);
    check("t1.re", dut.re, 64'd15);
    check("t1.flags", {62'd0, dut.rlt, dut.req}, 64'd2);

    run_op("t2", 64'd4, 64'd6, 64'd6, 32'hFFFF_FFFE, 32'd5, 32'd30, 32'd15, 1'b1);
    check("t2.rf", dut.rf, 64'hFFFF_FFFF_FFFF_FFFE);

    run_op("t3", 64'd1, 64'd9, 64'd2, 32'd10, 32'd10, 32'hFFFF_FFFE, 32'd5, 1'b0);

    run_op("t4", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
           32'd10, 32'd10, 1'b0);
    check("t4.rd", dut.rd, 64'd0);
    check("t4.rlt", 64'(dut.rlt), 64'd1);

    // start held high, operands changing every cycle; only every PER-th capture counts
    for (int i = 0; i < 3 * PER; i++) begin
      if (i % PER == 0) begin
        a = va[i / PER]; b = vb[i / PER]; c = vc[i / PER];
      end else begin
        a = 64'(i * 7 + 100); b = 64'(i * 3); c = 64'(i * 11 + 1);
      end
      start = 1'b1;
      tick();
      check("held.done", 64'(done), 64'((i % PER) == (PER - 1)));
      if ((i % PER) == (PER - 1)) begin
        check("held.x", 64'(x), 64'(vx[i / PER]));
        check("held.z", 64'(z), 64'(vz[i / PER]));
      end
    end
    start = 1'b0;
    tick();
    check("held.idle", {62'd0, done, busy}, 64'd0);

    // Reset asserted in SUB_F of an in-flight operation
    a = 64'd1; b = 64'd9; c = 64'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (LAT - 3) tick();
    check("rst.busy_before", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst.async_out", {30'd0, busy, done, 32'd0}, 64'd0);
    check("rst.async_zx", {z, x}, 64'd0);
    check("rst.rd", dut.rd, 64'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst.quiet", {62'd0, done, busy}, 64'd0);
    end

    run_op("fresh", 64'd5, 64'd3, 64'd10, 32'd30, 32'd15, 32'd0, 32'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/circuit4_sched.md
# circuit4_sched

Multi-cycle scheduled controller with datapath for the circuit_4 dataflow graph. It time-multiplexes one shared adder/subtractor across the three arithmetic operations and sequences the compare, select, shift and output-register steps with an FSM. A start/done handshake frames each computation. It replaces the fully parallel netlist wherever area is tighter than latency.

## Interface
- DW, 64, operand width; must be even and at least 4; outputs are DW/2 wide
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous, active-low reset
- start  input  1  request; accepted only in IDLE
- a, b, c  input  DW each  unsigned operands, sampled on the accepting edge
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse, coincident with new z/x
- z  output  DW/2  result z, held until the next completion
- x  output  DW/2  result x, held until the next completion

## Operation
- Function (all arithmetic mod 2^DW, unsigned):
  - d = a+b, e = a+c, f = a−b
  - lt = (d<e), eq = (d==e)
  - g = lt ? e : d
  - h = eq ? f : g
  - x = (h << lt)[DW/2−1:0]
  - z = (g >> eq)[DW/2−1:0]
- Shift amounts are the 1-bit flags, so each shift is by 0 or 1.
- Internal registers: ra, rb, rc, rd, re, rf, rlt, req, rg, rh.
- All internal registers reset to 0.
- States and actions:
  - IDLE: on start=1, capture a/b/c into ra/rb/rc and go to ADD_D. Otherwise stay.
  - ADD_D: ALU adds; rd ← ra+rb. Go to ADD_E.
  - ADD_E: ALU adds; re ← ra+rc. Go to SUB_F.
  - SUB_F: ALU subtracts; rf ← ra−rb. Comparator on rd/re loads rlt/req. Go to SEL.
  - SEL: rg, rh ← mux results. Go to OUT.
  - OUT: z, x ← shifted low halves of rg/rh; done ← 1. Go to IDLE.
- There is exactly one adder/subtractor instance. Its mode is decoded from the state.
- start while busy=1 is ignored. It is not queued.
- done registers low on every edge except the OUT→IDLE edge.
- Back-to-back: start may be asserted during the IDLE cycle where done=1. It is accepted, and z/x keep their values until the next OUT edge.
- Reset (any time, including mid-operation): state=IDLE, busy=0, done=0, z=0, x=0, all internal registers 0. No partial result appears on z/x.

## Timing
- Edge E0 is the rising edge where IDLE samples start=1.
- busy is high from E0 to E5. It is combinational from the state register, so no glitch risk.
- z, x and done update on E5, giving a latency of 5 edges.
- Throughput is one result per 6 cycles when start is held high.
- a/b/c only need to be valid at E0. Changes afterwards have no effect.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- CIRCUIT4_DUAL_ALU_EN:
  - Defined: a second adder is instantiated. ADD_D computes rd and re in the same cycle, and ADD_E is removed from the state encoding. Latency is 4 edges; throughput is one result per 5 cycles.
  - Undefined: single shared ALU and latency of 5 edges, as described above.
- Results are bit-identical in both configurations.

## Test plan
- DW=64, a=5, b=3, c=10, pulse start:
  - Expect d=8, e=15, lt=1, eq=0.
  - Expect x=30, z=15, done high one cycle at E5 (E4 with the macro), busy low afterwards.
- a=4, b=6, c=6 (equal case):
  - Expect f=0xFFFF_FFFF_FFFF_FFFE.
  - Expect x=0xFFFF_FFFE and z=5.
- a=1, b=9, c=2 (d>e):
  - Expect x=10, z=10.
- Wrap-around, a=2^64−1, b=1, c=0:
  - Expect d=0, lt=1.
  - Expect x=0xFFFF_FFFE, z=0xFFFF_FFFF.
- start held high with operands changed every cycle:
  - Only captures at E0, E6, E12… are used.
  - done fires every 6 cycles.
  - Extra start pulses while busy are ignored.
- Rst driven low in SUB_F of a second operation:
  - z, x, done and busy go to 0 immediately (asynchronously).
  - After release, IDLE with no done pulse.
  - A fresh start completes normally.
